// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver
//   HUB75 row-multiplexed scan engine with binary-code-modulated colour.
//   Reads a dual-half framebuffer through a 1-cycle RAM port and drives the
//   panel pins. One row pair is shifted and shown once per bit plane. Plane p
//   is shown for SHOW_BASE<<p ticks. A tick is one clk in every CLK_DIV.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous reset, active low
//   en          run enable, sampled only at frame boundaries
//   fb_addr     framebuffer read address {row, col}
//   fb_data     {r0,g0,b0,r1,g1,b1} (COLOR_BITS each), valid 1 clk after fb_addr
//   mat_r/g/b   colour data, [0] upper half, [1] lower half
//   mat_row     panel row address
//   mat_clk     shift clock
//   mat_lat     latch strobe, active high
//   mat_oe      output enable, active low
//   frame_done  one-clk pulse after the last plane of the last row
module hub75_scan_driver #(
    parameter int COLS       = 32,
    parameter int ROW_BITS   = 4,
    parameter int COLOR_BITS = 4,
    parameter int CLK_DIV    = 13,
    parameter int SHOW_BASE  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    output logic [ROW_BITS+$clog2(COLS)-1:0]     fb_addr,
    input  logic [6*COLOR_BITS-1:0]              fb_data,
    output logic [1:0]                           mat_r,
    output logic [1:0]                           mat_g,
    output logic [1:0]                           mat_b,
    output logic [ROW_BITS-1:0]                  mat_row,
    output logic                                 mat_clk,
    output logic                                 mat_lat,
    output logic                                 mat_oe,
    output logic                                 frame_done
);

    localparam int COL_BITS = $clog2(COLS);
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int PLANE_W  = $clog2(COLOR_BITS) + 1;
    localparam int SHOW_MAX = SHOW_BASE << (COLOR_BITS - 1);
    localparam int SHOW_W   = $clog2(SHOW_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREF  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_BLANK = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_SHOW  = 3'd5;

    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic [2:0]            state;
    logic [ROW_BITS-1:0]   row;
    logic [ROW_BITS-1:0]   row_next;
    logic [COL_BITS-1:0]   col;
    logic [COL_BITS-1:0]   col_next;
    logic [PLANE_W-1:0]    plane;
    logic                  phase_h;
    logic [SHOW_W-1:0]     show_cnt;
    logic [SHOW_W-1:0]     show_len;
    logic [COLOR_BITS-1:0] plane_mask;
    logic [5:0]            pix;       // {r0,g0,b0,r1,g1,b1} bits of the current plane
    logic                  last_plane;
    logic                  last_row;
    logic                  last_col;

    assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign row_next   = row + ROW_BITS'(1);
    assign col_next   = col + COL_BITS'(1);
    assign show_len   = SHOW_W'(SHOW_BASE) << plane;
    assign plane_mask = COLOR_BITS'(1) << plane;
    assign last_plane = (plane == PLANE_W'(COLOR_BITS - 1));
    assign last_row   = (row == '1);
    assign last_col   = (col == '1);

    // Channel k lives at fb_data[k*COLOR_BITS +: COLOR_BITS]; k=0 is b1, k=5 is r0.
    for (genvar k = 0; k < 6; k++) begin : g_pix
        assign pix[k] = |(fb_data[k*COLOR_BITS +: COLOR_BITS] & plane_mask);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt    <= '0;
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            plane      <= '0;
            phase_h    <= 1'b0;
            show_cnt   <= '0;
            fb_addr    <= '0;
            mat_r      <= '0;
            mat_g      <= '0;
            mat_b      <= '0;
            mat_row    <= '0;
            mat_clk    <= 1'b0;
            mat_lat    <= 1'b0;
            mat_oe     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        mat_oe  <= 1'b1;
                        mat_clk <= 1'b0;
                        mat_lat <= 1'b0;
                        if (en) begin
                            state   <= S_PREF;
                            row     <= '0;
                            plane   <= '0;
                            fb_addr <= '0;
                        end
                    end
                    S_PREF: begin
                        // fb_data for column 0 has settled by now; load it.
                        state   <= S_SHIFT;
                        col     <= '0;
                        phase_h <= 1'b0;
                        mat_clk <= 1'b0;
                        mat_r   <= {pix[2], pix[5]};
                        mat_g   <= {pix[1], pix[4]};
                        mat_b   <= {pix[0], pix[3]};
                    end
                    S_SHIFT: begin
                        if (!phase_h) begin
                            phase_h <= 1'b1;
                            mat_clk <= 1'b1;
                            // Prefetch the next pixel while the clock is high.
                            if (!last_col) fb_addr <= {row, col_next};
                        end else begin
                            phase_h <= 1'b0;
                            mat_clk <= 1'b0;
                            if (last_col) begin
                                state   <= S_BLANK;
                                mat_oe  <= 1'b1;
                                mat_row <= row;
                            end else begin
                                col   <= col_next;
                                mat_r <= {pix[2], pix[5]};
                                mat_g <= {pix[1], pix[4]};
                                mat_b <= {pix[0], pix[3]};
                            end
                        end
                    end
                    S_BLANK: begin
                        state   <= S_LATCH;
                        mat_lat <= 1'b1;
                    end
                    S_LATCH: begin
                        state    <= S_SHOW;
                        mat_lat  <= 1'b0;
                        mat_oe   <= 1'b0;
                        show_cnt <= show_len - SHOW_W'(1);
                    end
                    S_SHOW: begin
                        if (show_cnt != '0) begin
                            show_cnt <= show_cnt - SHOW_W'(1);
                        end else begin
                            mat_oe <= 1'b1;
                            state  <= S_PREF;
                            if (!last_plane) begin
                                plane   <= plane + PLANE_W'(1);
                                fb_addr <= {row, COL_BITS'(0)};
                            end else begin
                                plane   <= '0;
                                row     <= row_next;
                                fb_addr <= {row_next, COL_BITS'(0)};
                                if (last_row) begin
                                    frame_done <= 1'b1;
                                    if (!en) state <= S_IDLE;
                                end
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver
//   Self-checking bench for hub75_scan_driver. It uses a small panel
//   (COLS=4, ROW_BITS=1, COLOR_BITS=2, CLK_DIV=2, SHOW_BASE=1) and a
//   1-cycle framebuffer model.
//
// Ports: none (top-level bench).
module tb_hub75_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  fb_addr;
    logic [11:0] fb_data;
    logic [1:0]  mat_r, mat_g, mat_b;
    logic [0:0]  mat_row;
    logic        mat_clk, mat_lat, mat_oe, frame_done;

    logic [11:0] mem [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) fb_data <= mem[fb_addr];

    hub75_scan_driver #(
        .COLS(4), .ROW_BITS(1), .COLOR_BITS(2), .CLK_DIV(2), .SHOW_BASE(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fb_addr(fb_addr), .fb_data(fb_data),
        .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b),
        .mat_row(mat_row), .mat_clk(mat_clk), .mat_lat(mat_lat),
        .mat_oe(mat_oe), .frame_done(frame_done)
    );

    // Capture of {mat_r,mat_g,mat_b} at every shift-clock rise; index is
    // row*8 + plane*4 + col, restarted by frame_done.
    logic [5:0] cap [16];
    int         cap_idx = 0;
    logic       cap_prev_clk = 1'b0;

    always @(negedge clk) begin
        if (frame_done) cap_idx = 0;
        else if (mat_clk && !cap_prev_clk && cap_idx < 16) begin
            cap[cap_idx] = {mat_r, mat_g, mat_b};
            cap_idx++;
        end
        cap_prev_clk = mat_clk;
    end

    // Pin ordering watch: latch never overlaps lit output or shift clock,
    // row address only moves while blanked.
    int         order_viol = 0;
    int         frames_seen = 0;
    logic [0:0] prev_row = '0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mat_lat && (!mat_oe || mat_clk)) order_viol++;
            if (mat_row != prev_row && !mat_oe) order_viol++;
            if (frame_done) frames_seen++;
        end
        prev_row = mat_row;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fd(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Runs from a plane boundary (mat_oe high) to the next rising mat_oe.
    task automatic measure_plane(output int span, output int oe_low, output int rises,
                                 output int row_seen);
        logic poe, pck;
        span = 0; oe_low = 0; rises = 0; row_seen = -1;
        poe = mat_oe; pck = mat_clk;
        while (span < 200) begin
            @(negedge clk);
            span++;
            if (!mat_oe) begin
                oe_low++;
                row_seen = int'(mat_row);
            end
            if (mat_clk && !pck) rises++;
            if (mat_oe && !poe) break;
            poe = mat_oe;
            pck = mat_clk;
        end
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [11:0] data;
        int          idx_a;
        logic [5:0]  pins_a;
        int          idx_b;
        logic [5:0]  pins_b;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int  n, span, oel, rises, rs, others, quiet;
        bit  ok;

        // addr {row,col}; data {r0,g0,b0,r1,g1,b1}; pins {r[1],r[0],g[1],g[0],b[1],b[0]}
        vecs[0] = '{3'b010, 12'h800,  6, 6'h10,  2, 6'h00}; // r0=10 at row0 col2
        vecs[1] = '{3'b100, 12'h001,  8, 6'h02, 12, 6'h00}; // b1=01 at row1 col0
        vecs[2] = '{3'b111, 12'h300, 11, 6'h04, 15, 6'h04}; // g0=11 at row1 col3
        vecs[3] = '{3'b001, 12'h6E7,  1, 6'h1B,  5, 6'h27}; // all channels row0 col1
        vecs[4] = '{3'b011, 12'h030,  3, 6'h20,  7, 6'h20}; // r1=11 at row0 col3

        for (int unsigned i = 0; i < 8; i++) mem[i] = '0;
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_oe", mat_oe, 1);
        check("rst_lat", mat_lat, 0);
        check("rst_clk", mat_clk, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_done", frame_done, 0);
        check("rst_rgb", {mat_r, mat_g, mat_b}, 0);
        check("rst_row", mat_row, 0);

        rst = 1'b1;
        en  = 1'b1;

        // Plane timing and row address during SHOW.
        wait_fd(400, n, ok);
        check("first_frame_done", ok, 1);
        measure_plane(span, oel, rises, rs);
        check("p0_span_clk", span, 24);
        check("p0_oe_low", oel, 2);
        check("p0_shift_edges", rises, 4);
        check("p0_row", rs, 0);
        measure_plane(span, oel, rises, rs);
        check("p1_span_clk", span, 26);
        check("p1_oe_low", oel, 4);
        check("p1_shift_edges", rises, 4);
        check("p1_row", rs, 0);
        measure_plane(span, oel, rises, rs);
        check("row1_p0_span_clk", span, 24);
        check("row1_show_row", rs, 1);

        // Frame period.
        wait_fd(300, n, ok);
        check("align_fd", ok, 1);
        wait_fd(300, n, ok);
        check("frame_period", n, 100);

        // Data path vectors, one frame each.
        for (int unsigned v = 0; v < 5; v++) begin
            for (int unsigned i = 0; i < 8; i++) mem[i] = '0;
            mem[vecs[v].addr] = vecs[v].data;
            wait_fd(300, n, ok);
            check($sformatf("vec%0d_fd", v), ok, 1);
            check($sformatf("vec%0d_pins_a", v), cap[vecs[v].idx_a], vecs[v].pins_a);
            check($sformatf("vec%0d_pins_b", v), cap[vecs[v].idx_b], vecs[v].pins_b);
            others = 0;
            for (int i = 0; i < 16; i++)
                if (i != vecs[v].idx_a && i != vecs[v].idx_b && cap[i] != 6'h00) others++;
            check($sformatf("vec%0d_others_zero", v), others, 0);
        end
        for (int unsigned i = 0; i < 8; i++) mem[i] = '0;

        // Gating: drop en mid-frame, frame still completes on time.
        wait_fd(300, n, ok);
        check("gate_align_fd", ok, 1);
        repeat (30) @(negedge clk);
        en = 1'b0;
        wait_fd(300, n, ok);
        check("gate_frame_completes", ok, 1);
        check("gate_frame_period", n + 30, 100);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (!mat_oe || mat_clk || mat_lat || frame_done) quiet++;
        end
        check("idle_quiet", quiet, 0);
        en = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (mat_clk) break;
        end
        check("restart_first_edge_clk", n, 6);
        check("restart_addr", fb_addr, 1);

        // Reset while lit.
        n = 0;
        while (n < 300 && mat_oe) begin
            @(negedge clk);
            n++;
        end
        check("found_show", mat_oe, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midshow_rst_oe", mat_oe, 1);
        check("midshow_rst_lat", mat_lat, 0);
        check("midshow_rst_clk", mat_clk, 0);
        check("midshow_rst_addr", fb_addr, 0);
        check("midshow_rst_done", frame_done, 0);
        repeat (3) @(negedge clk);
        check("midshow_rst_hold_oe", mat_oe, 1);
        rst = 1'b1;
        wait_fd(400, n, ok);
        check("post_rst_frame_done", ok, 1);

        check("ordering_violations", order_viol, 0);
        check("frames_observed_ge3", frames_seen >= 3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Parametrised HUB75 dot-matrix scan engine that turns a dual-half framebuffer into row-multiplexed, binary-code-modulated (BCM) colour on an RGB LED panel. Sits between a framebuffer RAM (1-cycle read port) and the panel pins. It replaces the fixed divider-plus-driver pair with configurable columns, scan rows, colour depth, shift-clock divider and display time. It also adds frame gating and a frame-done strobe.

## Interface
- COLS, 32: pixels per row (shift length); power of two, ≥2
- ROW_BITS, 4: row address width; panel scans 2^ROW_BITS row pairs
- COLOR_BITS, 4: bits per colour channel = BCM planes
- CLK_DIV, 13: clk cycles per tick; ≥2
- SHOW_BASE, 1: ticks of OE-on for plane 0; plane p shows SHOW_BASE<<p ticks
- COL_BITS (derived) = $clog2(COLS)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  run enable; sampled at frame boundaries only
- fb_addr  out  ROW_BITS+COL_BITS  framebuffer read address {row, col}
- fb_data  in  6*COLOR_BITS  {r0,g0,b0,r1,g1,b1}, each COLOR_BITS; valid 1 clk after fb_addr; r0 = upper half row, r1 = lower half row (row + 2^ROW_BITS)
- mat_r, mat_g, mat_b  out  2 each  [0] upper half, [1] lower half
- mat_row  out  ROW_BITS  panel row address
- mat_clk  out  1  shift clock
- mat_lat  out  1  latch, active high
- mat_oe  out  1  output enable, active low (1 = blanked)
- frame_done  out  1  one-clk pulse after last plane of last row

## Operation
- Tick: counter 0..CLK_DIV-1; tick = (counter == CLK_DIV-1). State advances only on tick. Counter runs continuously from reset.
- States: IDLE, PREF, SHIFT, BLANK, LATCH, SHOW.
- IDLE: oe=1, clk=0, lat=0. On a tick with en=1 → PREF, with row=0 and plane=0.
- PREF (1 tick): fb_addr={row,0}.
- SHIFT (2*COLS ticks), for pixel c:
  - Phase L: data pins ← bit[plane] of each fb_data channel; mat_clk=0.
  - Phase H: mat_clk=1; fb_addr ← {row,c+1}. At c=COLS-1 fb_addr is not advanced.
  - Exit after phase H of the last pixel, with mat_clk returned to 0.
- BLANK (1 tick): oe=1, mat_row ← row, clk=0.
- LATCH (1 tick): lat=1. Data pins hold the last pixel.
- SHOW (SHOW_BASE<<plane ticks): oe=0, lat=0.
- After SHOW:
  - plane<COLOR_BITS-1: plane+1 → PREF.
  - Otherwise plane=0 and row+1 → PREF.
  - After the last row, row wraps to 0 and frame_done pulses for the clk after the SHOW-ending tick. Then → PREF if en=1, else → IDLE.
- en low mid-frame has no effect until the frame completes.
- mat_oe is 1 in every state except SHOW. mat_lat is 1 only in LATCH. mat_clk is 1 only in SHIFT phase H.
- Widths: plane counter $clog2(COLOR_BITS)+1 bits. The SHOW counter must hold SHOW_BASE<<(COLOR_BITS-1) without overflow. Column/row counters wrap modulo 2^n.

## Timing
- All outputs are registered and change one clk after the tick edge.
- Reset values (next clk with rst=0): state IDLE, tick counter 0, fb_addr 0, mat_r/g/b 0, mat_row 0, mat_clk 0, mat_lat 0, mat_oe 1, frame_done 0. Reset mid-SHIFT or mid-SHOW aborts immediately: OE goes high that clk, and there is no partial latch.
- fb_data is sampled CLK_DIV clk after fb_addr changes (≥2 ≥ RAM latency 1).
- Ticks per plane = 3 + 2*COLS + (SHOW_BASE<<plane).
- Frame ticks = 2^ROW_BITS × Σ_p plane ticks. With en held, frame_done pulses exactly once per frame period, which carries no extra ticks.

## Test plan
- Reset: hold rst=0 4 clk mid-SHOW → mat_oe=1, mat_lat=0, mat_clk=0, fb_addr=0, frame_done=0 on the clk after the first sampled low.
- Timing, with COLS=4, ROW_BITS=1, COLOR_BITS=2, CLK_DIV=2, SHOW_BASE=1 and en=1:
  - Plane 0 spans 12 ticks (24 clk) and plane 1 spans 13.
  - frame_done pulses every 100 clk.
  - 4 mat_clk rising edges per plane.
  - mat_oe low for 2 clk in plane 0 and 4 clk in plane 1.
- Data path: framebuffer pixel {row0,col2} r0=2'b10, all others 0 → mat_r[0]=1 only on the 3rd shift edge of plane 1 of row 0, and mat_r[0]=0 throughout plane 0.
- Lower half: {row1,col0} b1=2'b01 → mat_b[1]=1 on the 1st shift edge of plane 0 while shifting row 1. During that row's SHOW, mat_row=1.
- Gating: drop en mid-frame → the current frame completes and frame_done pulses, then IDLE with mat_oe=1. Raise en → PREF on the next tick, with fb_addr=0.
- Ordering: mat_lat=1 never coincides with mat_oe=0 or mat_clk=1. mat_row changes only while mat_oe=1, checked by assertion over 3 full frames.
